// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_pkg
//  Description : Shared types and helpers for the FIFO-fed UART transmitter:
//                FSM state encoding, counter-width helpers, parity function.
//                The PARITY state encoding is present only when
//                FIFO_UART_TX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    // Widest data word the parity helper accepts; callers zero-extend.
    localparam int c_PAR_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd6
    } tx_state_t;

    // Baud counter spans 0..div-1.
    function automatic int baud_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Bit counter must be able to hold the value data_w.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Even parity bit: XOR of all data bits (zero-extended input).
    function automatic logic even_parity(input logic [c_PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Free-running 0..CLK_DIV-1 counter for UART bit timing.
//                clear has priority over enable and returns the count to 0.
//  Ports       : clk, rst_n (async active-low)
//                clear    - synchronous return to 0
//                enable   - advance the count
//                tick     - count is at CLK_DIV-1 while enabled (terminal)
//                pre_tick - count is at CLK_DIV-2 while enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int              c_CNT_W = baud_cnt_w(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_TC  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_PRE = c_CNT_W'(CLK_DIV - 2);
    localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == c_TC) ? '0 : r_cnt + c_ONE;
        end
    end

    assign tick     = enable && (r_cnt == c_TC);
    assign pre_tick = enable && (r_cnt == c_PRE);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Read-side consumer of a synchronous FIFO. Pops one word when
//                the FIFO is not empty and sends it as a UART frame:
//                start (0), DATA_W bits LSB first, [even parity], stop (1).
//                Optional parity bit: define FIFO_UART_TX_PARITY_EN.
//  Ports       : clk        - system clock (rising edge)
//                rst_n      - asynchronous active-low reset
//                fifo_empty - FIFO empty flag
//                fifo_data  - FIFO data_out (valid the cycle after rd_en)
//                fifo_rd_en - one-cycle pop request
//                tx         - serial line, idles high
//                busy       - high in every state except IDLE
//                byte_done  - one-cycle pulse on the last cycle of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    localparam int                 c_BIT_W     = bit_cnt_w(DATA_W);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_ONE       = c_BIT_W'(1);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_nx;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_tx;
    logic               r_rd_en;
    logic               r_busy;
    logic               r_byte_done;
    logic               w_tx_next;
    logic               w_byte_done_next;
    logic               w_tick;
    logic               w_pre_tick;
    logic               w_baud_en;
    logic               w_baud_clr;
    logic               w_data_last;
    logic               w_stop_last;

`ifdef FIFO_UART_TX_PARITY_EN
    logic                   r_parity;
    logic [c_PAR_MAX_W-1:0] w_par_in;

    always_comb begin
        w_par_in               = '0;
        w_par_in[DATA_W-1:0]   = fifo_data;
    end
`endif

    // Counter runs only while a bit is on the line; any state change
    // restarts it so every state begins at count 0.
    assign w_baud_en  = (r_state == ST_START) || (r_state == ST_DATA) ||
`ifdef FIFO_UART_TX_PARITY_EN
                        (r_state == ST_PARITY) ||
`endif
                        (r_state == ST_STOP);
    assign w_baud_clr = (w_state_next != r_state);

    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_baud_clr),
        .enable   (w_baud_en),
        .tick     (w_tick),
        .pre_tick (w_pre_tick)
    );

    assign w_shift_nx  = r_shift >> 1;
    assign w_data_last = (r_bit_cnt == c_LAST_BIT);
    assign w_stop_last = (r_bit_cnt == c_LAST_STOP);

    // Next state plus next values of every registered output.
    always_comb begin
        w_state_next     = r_state;
        w_byte_done_next = 1'b0;
        w_tx_next        = 1'b1;

        case (r_state)
            ST_IDLE:  if (!fifo_empty) w_state_next = ST_POP;
            ST_POP:   w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_START;
            ST_START: if (w_tick) w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_tick && w_data_last) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: if (w_tick) w_state_next = ST_STOP;
`endif
            ST_STOP: begin
                // Registered pulse must land on the terminal cycle, so it is
                // launched one count early.
                if (w_pre_tick && w_stop_last) w_byte_done_next = 1'b1;
                if (w_tick && w_stop_last) begin
                    w_state_next = fifo_empty ? ST_IDLE : ST_POP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Line level for the cycle after this edge; changes only on state
        // entry or on a baud terminal count inside DATA.
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA: begin
                if (r_state != ST_DATA) w_tx_next = r_shift[0];
                else if (w_tick)        w_tx_next = w_shift_nx[0];
                else                    w_tx_next = r_tx;
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tx        <= 1'b1;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tx        <= w_tx_next;
            r_rd_en     <= (w_state_next == ST_POP);
            r_busy      <= (w_state_next != ST_IDLE);
            r_byte_done <= w_byte_done_next;
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_shift   <= fifo_data;
                    r_bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity  <= even_parity(w_par_in);
`endif
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift   <= w_shift_nx;
                        r_bit_cnt <= w_data_last ? '0 : r_bit_cnt + c_ONE;
                    end
                end
                // Reused to count stop bits.
                ST_STOP: begin
                    if (w_tick) r_bit_cnt <= w_stop_last ? '0 : r_bit_cnt + c_ONE;
                end
                default: ;
            endcase
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign byte_done  = r_byte_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Directed self-checking bench for fifo_uart_tx with
//                DATA_W=8, CLK_DIV=4, STOP_BITS=1. A queue models the FIFO.
//                Expected frames include the parity bit when
//                FIFO_UART_TX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif
    localparam int c_DIV = 4;
    localparam int c_FL  = c_DIV * (10 + c_PAR);   // frame length in cycles

    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    logic [7:0] fifo_q[$];
    int         n_total;
    int         n_bad;
    int         rd_cnt;

    fifo_uart_tx #(
        .DATA_W    (8),
        .CLK_DIV   (c_DIV),
        .STOP_BITS (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected line level for bit slot k of a frame carrying b.
    function automatic int exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 0;
        if (k <= 8) return int'(b[k-1]);
        if (c_PAR == 1 && k == 9) return int'(^b);
        return 1;
    endfunction

    // Advance to the next falling edge and service the FIFO model.
    task automatic cyc();
        @(negedge clk);
        if (fifo_rd_en) begin
            rd_cnt++;
            check_val("pop_nonempty", int'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Called in cycle T (the cycle whose closing edge sees empty=0 in IDLE
    // or is the stop terminal cycle). Returns at cycle T+2+frame.
    task automatic expect_frame(input logic [7:0] b);
        for (int n = 1; n <= c_FL + 2; n++) begin
            cyc();
            check_val($sformatf("rd_en b=%02h n=%0d", b, n), int'(fifo_rd_en), int'(n == 1));
            check_val($sformatf("busy b=%02h n=%0d", b, n), int'(busy), 1);
            check_val($sformatf("byte_done b=%02h n=%0d", b, n), int'(byte_done), int'(n == c_FL + 2));
            check_val($sformatf("tx b=%02h n=%0d", b, n), int'(tx),
                      (n < 3) ? 1 : exp_bit(b, (n - 3) / c_DIV));
        end
    endtask

    task automatic expect_idle(input string tag);
        check_val({tag, "_rd_en"}, int'(fifo_rd_en), 0);
        check_val({tag, "_tx"}, int'(tx), 1);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_byte_done"}, int'(byte_done), 0);
    endtask

    logic [7:0] rst_bytes[2];

    initial begin
        int rd0;
        n_total    = 0;
        n_bad      = 0;
        rd_cnt     = 0;
        rst_n      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;

        // Reset held while the clock runs.
        repeat (3) cyc();
        expect_idle("reset");
        rst_n = 1'b1;

        // Empty FIFO: nothing happens.
        for (int i = 0; i < 200; i++) begin
            cyc();
            expect_idle("idle200");
        end

        // Single byte.
        push(8'hA5);
        expect_frame(8'hA5);
        cyc();
        expect_idle("after_a5");

        // Five bytes back to back.
        rd0 = rd_cnt;
        for (int i = 1; i <= 5; i++) push(8'(i));
        for (int i = 1; i <= 5; i++) expect_frame(8'(i));
        cyc();
        expect_idle("after_burst");
        check_val("burst_pops", rd_cnt - rd0, 5);
        check_val("burst_empty", int'(fifo_empty), 1);

        // Parity-sensitive byte (three ones).
        push(8'h07);
        expect_frame(8'h07);
        cyc();
        expect_idle("after_07");

        // Reset during data bit 3; partial byte is dropped.
        rst_bytes[0] = 8'hFF;
        rst_bytes[1] = 8'h00;
        for (int r = 0; r < 2; r++) begin
            push(rst_bytes[r]);
            for (int n = 1; n <= 20; n++) cyc();
            check_val($sformatf("pre_rst_tx b=%02h", rst_bytes[r]), int'(tx), int'(rst_bytes[r][3]));
            #2 rst_n = 1'b0;
            #1;
            expect_idle("async_rst");
            repeat (2) cyc();
            rst_n = 1'b1;
            rd0 = rd_cnt;
            for (int i = 0; i < 100; i++) begin
                cyc();
                check_val("post_rst_rd_en", int'(fifo_rd_en), 0);
                check_val("post_rst_tx", int'(tx), 1);
            end
            check_val("post_rst_pops", rd_cnt - rd0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
